ikbd_sci_link: RTL

//  Serial-link controller between the host-side keyboard interface and the HD63701 SCI (8N1).
//  It queues host command bytes in a FIFO and serialises them onto the MCU RX pin (PI2[3]).
//  It deserialises MCU TX (PO2[4]) into a host holding register, with overrun and framing flags.
//  Bit timing counts mcu_en ticks: use the same enable as the SCI so both sides agree on 256 ticks/bit.

---
 rtl/ikbd_sci_link.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ikbd_sci_link.sv
// Serial link between the host keyboard interface and the HD63701 SCI (8N1).
// The host TX FIFO is serialised onto mcu_rx; mcu_tx is deserialised into a host holding register.
module ikbd_sci_link #(
  parameter int unsigned BIT_TICKS  = 256,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          mcu_clk,
  input  logic                          mcu_rst,
  input  logic                          mcu_en,
  input  logic [7:0]                    host_tx_data,
  input  logic                          host_tx_valid,
  output logic                          host_tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   tx_level,
  output logic                          tx_busy,
  output logic                          mcu_rx,
  input  logic                          mcu_tx,
  output logic [7:0]                    host_rx_data,
  output logic                          host_rx_valid,
  input  logic                          host_rx_ack,
  output logic                          rx_overrun,
  output logic                          rx_frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(BIT_TICKS);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_FULL  = CW'(BIT_TICKS - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(BIT_TICKS / 2 - 1);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  // ---------------- TX FIFO ----------------
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level;
  logic          push, pop, fifo_nonempty;

  assign host_tx_ready = (level != LVL_FULL);
  assign push          = host_tx_valid & host_tx_ready;
  assign fifo_nonempty = (level != '0);
  assign tx_level      = level;

  always_ff @(posedge mcu_clk) begin
    if (push) fifo_mem[wr_ptr] <= host_tx_data;
  end

  always_ff @(posedge mcu_clk or posedge mcu_rst) begin
    if (mcu_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
    end
  end

  // ---------------- TX FSM ----------------
  tx_state_t     tx_state, tx_next;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [9:0]    tx_frame;
  logic          tx_tick_end, tx_shift;

  assign tx_tick_end = (tx_cnt == CNT_FULL);

  always_ff @(posedge mcu_clk or posedge mcu_rst) begin
    if (mcu_rst) tx_state <= TX_IDLE;
    else         tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    if (mcu_en) begin
      unique case (tx_state)
        TX_IDLE:  if (fifo_nonempty) tx_next = TX_START;
        TX_START: if (tx_tick_end) tx_next = TX_DATA;
        TX_DATA:  if (tx_tick_end && tx_bit == 3'd7) tx_next = TX_STOP;
        TX_STOP:  if (tx_tick_end) tx_next = fifo_nonempty ? TX_START : TX_IDLE;
        default:  tx_next = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    pop      = mcu_en & fifo_nonempty &
               ((tx_state == TX_IDLE) | ((tx_state == TX_STOP) & tx_tick_end));
    tx_shift = mcu_en & tx_tick_end & ((tx_state == TX_START) | (tx_state == TX_DATA));
    tx_busy  = (tx_state != TX_IDLE) | fifo_nonempty;
  end

  // The whole frame {stop, data, start} is held in a shift register whose LSB is the line,
  // so mcu_rx is a flop output and shifting in ones leaves the line idle high.
  always_ff @(posedge mcu_clk or posedge mcu_rst) begin
    if (mcu_rst) begin
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_frame <= '1;
    end else if (mcu_en) begin
      tx_cnt <= (tx_state == TX_IDLE || tx_tick_end) ? '0 : tx_cnt + 1'b1;
      if (pop)           tx_frame <= {1'b1, fifo_mem[rd_ptr], 1'b0};
      else if (tx_shift) tx_frame <= {1'b1, tx_frame[9:1]};
      if (tx_state == TX_DATA && tx_tick_end) tx_bit <= tx_bit + 1'b1;
    end
  end

  assign mcu_rx = tx_frame[0];

  // ---------------- RX path ----------------
  logic [1:0]    rx_sync;
  logic          rx_s, rx_prev;
  rx_state_t     rx_state, rx_next;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shreg;
  logic          rx_half_end, rx_full_end, rx_sample, rx_stop_strobe;
  logic          deliver_ok, deliver_err;

  assign rx_s        = rx_sync[1];
  assign rx_half_end = (rx_cnt == CNT_HALF);
  assign rx_full_end = (rx_cnt == CNT_FULL);

  always_ff @(posedge mcu_clk or posedge mcu_rst) begin
    if (mcu_rst) rx_sync <= '1;
    else         rx_sync <= {rx_sync[0], mcu_tx};
  end

  always_ff @(posedge mcu_clk or posedge mcu_rst) begin
    if (mcu_rst) rx_state <= RX_IDLE;
    else         rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    if (mcu_en) begin
      unique case (rx_state)
        RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
        RX_START: if (rx_half_end) rx_next = rx_s ? RX_IDLE : RX_DATA;
        RX_DATA:  if (rx_full_end && rx_bit == 3'd7) rx_next = RX_STOP;
        RX_STOP:  if (rx_full_end) rx_next = RX_IDLE;
        default:  rx_next = RX_IDLE;
      endcase
    end
  end

  always_comb begin
    rx_sample      = mcu_en & (rx_state == RX_DATA) & rx_full_end;
    rx_stop_strobe = mcu_en & (rx_state == RX_STOP) & rx_full_end;
    deliver_ok     = rx_stop_strobe & rx_s;
    deliver_err    = rx_stop_strobe & ~rx_s;
  end

  always_ff @(posedge mcu_clk or posedge mcu_rst) begin
    if (mcu_rst) begin
      rx_prev  <= 1'b1;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
    end else if (mcu_en) begin
      rx_prev <= rx_s;
      rx_cnt  <= (rx_state == RX_IDLE || (rx_state == RX_START && rx_half_end) || rx_full_end)
                 ? '0 : rx_cnt + 1'b1;
      if (rx_state == RX_IDLE) rx_bit <= '0;
      if (rx_sample) begin
        rx_shreg <= {rx_s, rx_shreg[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end
    end
  end

  // Ack clears first; a delivery in the same cycle then overrides with its own effects.
  always_ff @(posedge mcu_clk or posedge mcu_rst) begin
    if (mcu_rst) begin
      host_rx_data  <= '0;
      host_rx_valid <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      if (host_rx_ack) begin
        host_rx_valid <= 1'b0;
        rx_overrun    <= 1'b0;
        rx_frame_err  <= 1'b0;
      end
      if (deliver_ok) begin
        if (!host_rx_valid || host_rx_ack) begin
          host_rx_data  <= rx_shreg;
          host_rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
      if (deliver_err) rx_frame_err <= 1'b1;
    end
  end

endmodule
